// File: rtl/axim_id_tracker_pkg.sv
// Shared types and helpers for the AXI per-ID outstanding-transaction tracker.
package axim_id_tracker_pkg;

  // Error class reported through the first-error capture port.
  typedef enum logic [1:0] {
    TRK_NONE  = 2'd0,
    TRK_UNEXP = 2'd1,
    TRK_OVF   = 2'd2,
    TRK_TMO   = 2'd3
  } trk_err_e;

  // Initiator ID of the vector extension unit.
  localparam logic [3:0] AMBAID4_VEXD = 4'd4;

  // Error code of one ID's new errors; UNEXP beats OVF beats TMO.
  function automatic trk_err_e trk_code(input logic unexp, input logic ovf, input logic tmo);
    trk_err_e code;
    if (unexp) begin
      code = TRK_UNEXP;
    end else if (ovf) begin
      code = TRK_OVF;
    end else if (tmo) begin
      code = TRK_TMO;
    end else begin
      code = TRK_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/axim_id_slot.sv
// One tracked ID: saturating outstanding counter, no-response watchdog and
// three sticky error flags. new_*_o flag the cycle an error event occurs.
module axim_id_slot
  import axim_id_tracker_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int TMO_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic aclk_i,
  input  logic aresetn_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic beat_i,
  input  logic clr_i,
  output logic busy_o,
  output logic err_unexp_o,
  output logic err_ovf_o,
  output logic err_tmo_o,
  output logic new_unexp_o,
  output logic new_ovf_o,
  output logic new_tmo_o,
  output logic err_any_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic             err_unexp_q, err_unexp_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_tmo_q, err_tmo_d;
  logic             new_unexp_s, new_ovf_s, new_tmo_s;

  // Outstanding count: simultaneous inc/dec cancel, otherwise saturate at both ends.
  always_comb begin
    cnt_d       = cnt_q;
    new_unexp_s = 1'b0;
    new_ovf_s   = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) begin
        new_ovf_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == CNT_ZERO) begin
        new_unexp_s = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog: restarts on any beat or when idle, counts up while busy and parks at the limit.
  always_comb begin
    tmr_d     = tmr_q;
    new_tmo_s = 1'b0;
    if (!TMO_EN || beat_i || (cnt_q == CNT_ZERO)) begin
      tmr_d = TMO_ZERO;
    end else if (tmr_q != TMO_LIM) begin
      tmr_d     = tmr_q + TMO_ONE;
      new_tmo_s = ((tmr_q + TMO_ONE) == TMO_LIM);
    end else begin
      tmr_d = tmr_q;
    end
  end

  // Sticky flags: a new error in the clear cycle keeps its bit set.
  always_comb begin
    err_unexp_d = new_unexp_s | (err_unexp_q & ~clr_i);
    err_ovf_d   = new_ovf_s   | (err_ovf_q   & ~clr_i);
    err_tmo_d   = new_tmo_s   | (err_tmo_q   & ~clr_i);
  end

  // Slot state registers.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q       <= CNT_ZERO;
      tmr_q       <= TMO_ZERO;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      err_unexp_q <= err_unexp_d;
      err_ovf_q   <= err_ovf_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign busy_o      = (cnt_q != CNT_ZERO);
  assign err_unexp_o = err_unexp_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_tmo_o   = err_tmo_q;
  assign new_unexp_o = new_unexp_s;
  assign new_ovf_o   = new_ovf_s;
  assign new_tmo_o   = new_tmo_s;
  assign err_any_d_o = err_unexp_d | err_ovf_d | err_tmo_d;

endmodule

// File: rtl/axim_id_tracker.sv
// Passive AXI request/response snooper: per-ID outstanding tracking, sticky
// protocol-fault flags, first-error capture and a maskable interrupt.
module axim_id_tracker
  import axim_id_tracker_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int CNT_W       = 6,
  parameter int TMO_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   req_valid,
  input  logic                   req_ready,
  input  logic [ID_W-1:0]        req_id,
  input  logic                   rsp_valid,
  input  logic                   rsp_ready,
  input  logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_last,
  input  logic                   err_clr,
  input  logic [(1<<ID_W)-1:0]   err_clr_ids,
  input  logic [(1<<ID_W)-1:0]   irq_mask,
  output logic [(1<<ID_W)-1:0]   busy,
  output logic                   idle,
  output logic [(1<<ID_W)-1:0]   err_unexp,
  output logic [(1<<ID_W)-1:0]   err_ovf,
  output logic [(1<<ID_W)-1:0]   err_tmo,
  output logic                   err_first_vld,
  output logic [ID_W-1:0]        err_first_id,
  output logic [1:0]             err_first_code,
  output logic                   irq
);

  localparam int NID = 1 << ID_W;

  logic [NID-1:0] inc_s, dec_s, beat_s, clr_s;
  logic [NID-1:0] new_unexp_s, new_ovf_s, new_tmo_s, err_any_d_s;
  logic           req_hs_s, rsp_hs_s;

  logic           hit_s;
  logic [ID_W-1:0] hit_id_s;
  trk_err_e       hit_code_s;

  logic           first_vld_q, first_vld_d;
  logic [ID_W-1:0] first_id_q, first_id_d;
  trk_err_e       first_code_q, first_code_d;
  logic           irq_q, irq_d;

  assign req_hs_s = req_valid & req_ready;
  assign rsp_hs_s = rsp_valid & rsp_ready;

  // Decode handshakes into one-hot per-ID events.
  always_comb begin
    inc_s  = {NID{1'b0}};
    beat_s = {NID{1'b0}};
    dec_s  = {NID{1'b0}};
    clr_s  = {NID{1'b0}};
    for (int i = 0; i < NID; i++) begin
      inc_s[i]  = req_hs_s & (req_id == ID_W'(i));
      beat_s[i] = rsp_hs_s & (rsp_id == ID_W'(i));
      dec_s[i]  = beat_s[i] & rsp_last;
      clr_s[i]  = err_clr & err_clr_ids[i];
    end
  end

  for (genvar g = 0; g < NID; g++) begin : g_slot
    axim_id_slot #(
      .CNT_W       (CNT_W),
      .TMO_W       (TMO_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_slot (
      .aclk_i      (aclk),
      .aresetn_i   (aresetn),
      .inc_i       (inc_s[g]),
      .dec_i       (dec_s[g]),
      .beat_i      (beat_s[g]),
      .clr_i       (clr_s[g]),
      .busy_o      (busy[g]),
      .err_unexp_o (err_unexp[g]),
      .err_ovf_o   (err_ovf[g]),
      .err_tmo_o   (err_tmo[g]),
      .new_unexp_o (new_unexp_s[g]),
      .new_ovf_o   (new_ovf_s[g]),
      .new_tmo_o   (new_tmo_s[g]),
      .err_any_d_o (err_any_d_s[g])
    );
  end

  // Priority encoder over this cycle's new errors: scanning downwards lets the lowest ID win.
  always_comb begin
    hit_s      = 1'b0;
    hit_id_s   = {ID_W{1'b0}};
    hit_code_s = TRK_NONE;
    for (int i = NID - 1; i >= 0; i--) begin
      if (new_unexp_s[i] | new_ovf_s[i] | new_tmo_s[i]) begin
        hit_s      = 1'b1;
        hit_id_s   = ID_W'(i);
        hit_code_s = trk_code(new_unexp_s[i], new_ovf_s[i], new_tmo_s[i]);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // First-error capture: armed when empty or on err_clr; err_clr without a new error re-arms it.
  always_comb begin
    first_vld_d  = first_vld_q;
    first_id_d   = first_id_q;
    first_code_d = first_code_q;
    if ((!first_vld_q || err_clr) && hit_s) begin
      first_vld_d  = 1'b1;
      first_id_d   = hit_id_s;
      first_code_d = hit_code_s;
    end else if (err_clr) begin
      first_vld_d  = 1'b0;
      first_id_d   = {ID_W{1'b0}};
      first_code_d = TRK_NONE;
    end else begin
      first_vld_d  = first_vld_q;
    end
  end

  // Interrupt follows the sticky flags as they will be after this edge, gated by the mask.
  always_comb begin
    irq_d = |(err_any_d_s & irq_mask);
  end

  // Capture and interrupt registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_vld_q  <= 1'b0;
      first_id_q   <= {ID_W{1'b0}};
      first_code_q <= TRK_NONE;
      irq_q        <= 1'b0;
    end else begin
      first_vld_q  <= first_vld_d;
      first_id_q   <= first_id_d;
      first_code_q <= first_code_d;
      irq_q        <= irq_d;
    end
  end

  assign idle           = ~|busy;
  assign err_first_vld  = first_vld_q;
  assign err_first_id   = first_id_q;
  assign err_first_code = first_code_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_axim_id_tracker.sv
// Directed bench for axim_id_tracker with a per-ID scoreboard model compared every cycle.
module tb_axim_id_tracker;
  import axim_id_tracker_pkg::*;

  localparam int TMO = 16;
  localparam int MAXC = 63;

  logic        aclk, aresetn;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, err_clr;
  logic [3:0]  req_id, rsp_id;
  logic [15:0] err_clr_ids, irq_mask;
  logic [15:0] busy, err_unexp, err_ovf, err_tmo;
  logic        idle, err_first_vld, irq;
  logic [3:0]  err_first_id;
  logic [1:0]  err_first_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard model state
  int          m_cnt [16];
  int          m_age [16];
  logic [15:0] m_eu, m_eo, m_et;
  bit          m_fvld, m_irq;
  int          m_fid, m_fcode;

  axim_id_tracker #(.ID_W(4), .CNT_W(6), .TMO_W(16), .TIMEOUT_CYC(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .err_clr(err_clr), .err_clr_ids(err_clr_ids), .irq_mask(irq_mask),
    .busy(busy), .idle(idle), .err_unexp(err_unexp), .err_ovf(err_ovf), .err_tmo(err_tmo),
    .err_first_vld(err_first_vld), .err_first_id(err_first_id),
    .err_first_code(err_first_code), .irq(irq)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 0;
      m_age[i] = 0;
    end
    m_eu = 16'h0; m_eo = 16'h0; m_et = 16'h0;
    m_fvld = 1'b0; m_fid = 0; m_fcode = 0; m_irq = 1'b0;
  endtask

  // Apply the handshakes seen at this clock edge to the model.
  task automatic model_step();
    logic [15:0] nu, no, nt, clrv;
    bit found;
    int fid, fcode;
    nu = 16'h0; no = 16'h0; nt = 16'h0;
    clrv = err_clr ? err_clr_ids : 16'h0;
    for (int i = 0; i < 16; i++) begin
      bit inc, beat, dec;
      int prev;
      inc  = req_valid && req_ready && (int'(req_id) == i);
      beat = rsp_valid && rsp_ready && (int'(rsp_id) == i);
      dec  = beat && rsp_last;
      prev = m_cnt[i];
      if (inc && !dec) begin
        if (prev == MAXC) no[i] = 1'b1;
        else m_cnt[i] = prev + 1;
      end else if (dec && !inc) begin
        if (prev == 0) nu[i] = 1'b1;
        else m_cnt[i] = prev - 1;
      end
      if (beat || prev == 0) m_age[i] = 0;
      else if (m_age[i] < TMO) begin
        m_age[i] = m_age[i] + 1;
        if (m_age[i] == TMO) nt[i] = 1'b1;
      end
    end
    m_eu = nu | (m_eu & ~clrv);
    m_eo = no | (m_eo & ~clrv);
    m_et = nt | (m_et & ~clrv);
    found = 1'b0; fid = 0; fcode = 0;
    for (int i = 0; i < 16; i++) begin
      if (!found && (nu[i] || no[i] || nt[i])) begin
        found = 1'b1;
        fid = i;
        fcode = nu[i] ? 1 : (no[i] ? 2 : 3);
      end
    end
    if ((!m_fvld || err_clr) && found) begin
      m_fvld = 1'b1; m_fid = fid; m_fcode = fcode;
    end else if (err_clr) begin
      m_fvld = 1'b0; m_fid = 0; m_fcode = 0;
    end
    m_irq = |((m_eu | m_eo | m_et) & irq_mask);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step();
    end
  end

  task automatic compare_all();
    logic [15:0] mb;
    mb = 16'h0;
    for (int i = 0; i < 16; i++) mb[i] = (m_cnt[i] != 0);
    check("busy", busy, mb);
    check("idle", idle, mb == 16'h0);
    check("err_unexp", err_unexp, m_eu);
    check("err_ovf", err_ovf, m_eo);
    check("err_tmo", err_tmo, m_et);
    check("first_vld", err_first_vld, m_fvld);
    check("first_id", err_first_id, m_fvld ? m_fid : 0);
    check("first_code", err_first_code, m_fvld ? m_fcode : 0);
    check("irq", irq, m_irq);
  endtask

  // Per-cycle model comparison, just after each active edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      compare_all();
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_ready = 1'b0; req_id = 4'd0;
    rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_id = 4'd0; rsp_last = 1'b0;
    err_clr = 1'b0; err_clr_ids = 16'h0;
  endtask

  task automatic do_req(input logic [3:0] id);
    req_valid = 1'b1; req_ready = 1'b1; req_id = id;
    tick();
    drive_idle();
  endtask

  task automatic do_rsp(input logic [3:0] id, input logic last);
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = id; rsp_last = last;
    tick();
    drive_idle();
  endtask

  task automatic clear_all();
    err_clr = 1'b1; err_clr_ids = 16'hFFFF;
    tick();
    drive_idle();
  endtask

  initial begin
    drive_idle();
    aresetn  = 1'b0;
    irq_mask = 16'hFFFF;
    repeat (3) tick();
    check("rst_idle", idle, 1);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    aresetn = 1'b1;
    tick();

    // Three requests on the VEXD ID, then three four-beat bursts
    do_req(AMBAID4_VEXD);
    check("vexd_busy_first", busy[4], 1);
    req_valid = 1'b1; req_ready = 1'b0; req_id = 4'd4;   // no handshake
    tick();
    drive_idle();
    do_req(AMBAID4_VEXD);
    do_req(AMBAID4_VEXD);
    check("model_cnt4", m_cnt[4], 3);
    rsp_valid = 1'b1; rsp_ready = 1'b0; rsp_id = 4'd4; rsp_last = 1'b1;  // no handshake
    tick();
    drive_idle();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 4; k++) do_rsp(4'd4, k == 3);
    check("vexd_busy_done", busy[4], 0);
    check("vexd_idle", idle, 1);
    check("vexd_noerr", err_unexp | err_ovf | err_tmo, 0);

    // Request and completion on ID 2 in one cycle at count 0
    req_valid = 1'b1; req_ready = 1'b1; req_id = 4'd2;
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = 4'd2; rsp_last = 1'b1;
    tick();
    drive_idle();
    check("same_cyc_unexp2", err_unexp[2], 0);
    check("same_cyc_idle", idle, 1);

    // Unexpected B response on ID 7
    do_rsp(4'd7, 1'b1);
    check("unexp7", err_unexp, 16'h0080);
    check("unexp7_vld", err_first_vld, 1);
    check("unexp7_id", err_first_id, 7);
    check("unexp7_code", err_first_code, TRK_UNEXP);
    check("unexp7_irq", irq, 1);
    irq_mask = 16'hFF7F;
    tick();
    check("unexp7_irq_masked", irq, 0);
    irq_mask = 16'hFFFF;
    clear_all();
    check("clr_all", err_unexp | err_ovf | err_tmo, 0);

    // 64 requests on ID 5; non-last beats keep the watchdog quiet
    for (int n = 0; n < 64; n++) begin
      req_valid = 1'b1; req_ready = 1'b1; req_id = 4'd5;
      rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = 4'd5; rsp_last = 1'b0;
      tick();
      drive_idle();
      if (n == 62) check("ovf5_before", err_ovf[5], 0);
    end
    check("model_cnt5", m_cnt[5], 63);
    check("ovf5", err_ovf, 16'h0020);
    check("ovf5_id", err_first_id, 5);
    check("ovf5_code", err_first_code, TRK_OVF);
    check("ovf5_tmo", err_tmo, 0);
    for (int n = 0; n < 63; n++) do_rsp(4'd5, 1'b1);
    check("ovf5_drain_busy", busy[5], 0);
    check("ovf5_drain_unexp", err_unexp[5], 0);
    clear_all();

    // Watchdog on ID 13
    do_req(4'd13);
    repeat (15) tick();
    check("tmo13_early", err_tmo[13], 0);
    tick();
    check("tmo13", err_tmo, 16'h2000);
    check("tmo13_id", err_first_id, 13);
    check("tmo13_code", err_first_code, TRK_TMO);
    do_rsp(4'd13, 1'b1);
    clear_all();
    do_req(4'd13);
    repeat (10) tick();
    do_rsp(4'd13, 1'b0);
    repeat (10) tick();
    check("tmo13_beat_saves", err_tmo[13], 0);
    check("tmo13_still_busy", busy[13], 1);
    do_rsp(4'd13, 1'b1);

    // Clear-all racing a new unexpected completion on ID 3
    do_rsp(4'd9, 1'b1);
    check("unexp9", err_unexp, 16'h0200);
    err_clr = 1'b1; err_clr_ids = 16'hFFFF;
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = 4'd3; rsp_last = 1'b1;
    tick();
    drive_idle();
    check("clr_race_unexp", err_unexp, 16'h0008);
    check("clr_race_id", err_first_id, 3);
    check("clr_race_code", err_first_code, TRK_UNEXP);

    // Reset in the middle of a burst
    do_req(4'd1);
    do_req(4'd1);
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = 4'd1; rsp_last = 1'b0;
    tick();
    aresetn = 1'b0;
    drive_idle();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_err", err_unexp | err_ovf | err_tmo, 0);
    check("mid_rst_first", {err_first_vld, err_first_id, err_first_code}, 0);
    check("mid_rst_irq", irq, 0);
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
